// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared types for the RAM arbiter and its round-robin picker.
package memory_arbiter_pkg;
  typedef logic [31:0] word_t;
  typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
  typedef enum logic {IDLE, XFER} arb_state_t;
  typedef struct packed {
    logic [1:0] cpu;
    logic       is_data;
    logic       is_write;
  } owner_t;
  function automatic logic [1:0] next_ptr(input logic [1:0] c, input int n);
    return (int'(c) == n - 1) ? 2'd0 : c + 2'd1;
  endfunction
endpackage

// File: rtl/memory_arbiter_rr_picker.sv
// rr_picker: combinational round-robin winner search starting at i_ptr.
// Request vector is always 4 wide; only the low CPUS bits take part.
module rr_picker #(
  parameter int CPUS = 1
) (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_idx,
  output logic       o_valid
);
  always_comb begin
    int j;
    j = 0;
    o_idx = '0;
    o_valid = 1'b0;
    // Walk from farthest to nearest so the slot closest to i_ptr wins last.
    for (int k = CPUS - 1; k >= 0; k--) begin
      j = (int'(i_ptr) + k) % CPUS;
      if (i_req[j[1:0]]) begin
        o_idx = j[1:0];
        o_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: single-port RAM sequencer between per-CPU caches and system RAM.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int CPUS    = 1,
  parameter int TIMEOUT = 255
) (
  input  logic               CLK,
  input  logic               nRST,
  input  logic [CPUS-1:0]    iREN,
  input  logic [CPUS-1:0]    dREN,
  input  logic [CPUS-1:0]    dWEN,
  input  logic [CPUS*32-1:0] iaddr,
  input  logic [CPUS*32-1:0] daddr,
  input  logic [CPUS*32-1:0] dstore,
  output logic [CPUS-1:0]    iwait,
  output logic [CPUS-1:0]    dwait,
  output logic [CPUS*32-1:0] iload,
  output logic [CPUS*32-1:0] dload,
  output logic               ramREN,
  output logic               ramWEN,
  output logic [31:0]        ramaddr,
  output logic [31:0]        ramstore,
  input  logic [31:0]        ramload,
  input  logic [1:0]         ramstate,
  output logic               arb_err
);
  logic [3:0] w_iren, w_dren, w_dwen, w_req;
  logic [127:0] w_iaddr, w_daddr, w_dstore;
  arb_state_t r_state, w_next;
  owner_t r_own;
  logic [1:0] r_rr, w_win;
  logic w_valid, w_xfer, w_live, w_done, w_to;
  word_t w_ia, w_da, w_ds;
  // Pad per-CPU vectors to the 4-CPU maximum so a 2-bit owner index is always legal.
  assign w_iren = 4'(iREN);
  assign w_dren = 4'(dREN);
  assign w_dwen = 4'(dWEN);
  assign w_iaddr = 128'(iaddr);
  assign w_daddr = 128'(daddr);
  assign w_dstore = 128'(dstore);
  assign w_req = w_iren | w_dren | w_dwen;
  rr_picker #(.CPUS(CPUS)) u_pick (
    .i_req  (w_req),
    .i_ptr  (r_rr),
    .o_idx  (w_win),
    .o_valid(w_valid)
  );
  assign w_xfer = r_state == XFER;
  assign w_ia = w_iaddr[{r_own.cpu, 5'd0} +: 32];
  assign w_da = w_daddr[{r_own.cpu, 5'd0} +: 32];
  assign w_ds = w_dstore[{r_own.cpu, 5'd0} +: 32];
  assign w_live = r_own.is_write ? w_dwen[r_own.cpu] :
                  r_own.is_data  ? w_dren[r_own.cpu] : w_iren[r_own.cpu];
  assign w_done = w_xfer && w_live && ramstate_t'(ramstate) == ACCESS;
`ifdef MEM_ARB_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic r_err;
  assign w_to = w_xfer && w_live && !w_done && r_cnt == 8'(TIMEOUT - 1);
  assign arb_err = r_err;
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= w_xfer ? r_cnt + 8'd1 : 8'd0;
      if (w_to) r_err <= 1'b1;
    end
  end
`else
  assign w_to = 1'b0;
  assign arb_err = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    if (!w_xfer) w_next = w_valid ? XFER : IDLE;
    else if (w_done || !w_live || w_to) w_next = IDLE;
  end
  always_comb begin
    ramREN = w_xfer && w_live && !r_own.is_write;
    ramWEN = w_xfer && w_live && r_own.is_write;
    ramaddr = !w_xfer ? '0 : r_own.is_data ? w_da : w_ia;
    ramstore = (w_xfer && r_own.is_data) ? w_ds : '0;
    iwait = '1;
    dwait = '1;
    iload = '0;
    dload = '0;
    for (int c = 0; c < CPUS; c++) begin
      if (w_done && 2'(c) == r_own.cpu) begin
        if (r_own.is_data) begin
          dwait[c] = 1'b0;
          if (!r_own.is_write) dload[c*32 +: 32] = ramload;
        end else begin
          iwait[c] = 1'b0;
          iload[c*32 +: 32] = ramload;
        end
      end
    end
  end
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state <= IDLE;
      r_rr <= '0;
      r_own <= '0;
    end else begin
      r_state <= w_next;
      if (!w_xfer && w_valid) r_own <= '{w_win, w_dren[w_win] | w_dwen[w_win], w_dwen[w_win]};
      // Aborts from a dropped request leave the pointer; completions and timeouts advance it.
      if (w_done || w_to) r_rr <= next_ptr(r_own.cpu, CPUS);
    end
  end
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: table-driven check of the two-CPU arbiter plus reset and watchdog sequences.
module tb_memory_arbiter;
  import memory_arbiter_pkg::*;
  localparam logic [31:0] L = 32'h2408_0001;
  logic clk = 1'b0;
  logic nrst;
  logic [1:0] iren, dren, dwen, rs, iwait, dwait;
  logic [63:0] iaddr, daddr, dstore, iload, dload;
  logic ren, wen, err;
  logic [31:0] raddr, rstore, rload;
  int errors = 0;
  int checks = 0;
  typedef struct {
    logic [1:0] iren, dren, dwen, rs, iw, dw;
    logic ren, wen;
    logic [31:0] addr, store;
    logic [63:0] il, dl;
  } vec_t;
  vec_t v[$];
  always #5 clk = ~clk;
  memory_arbiter #(.CPUS(2), .TIMEOUT(8)) dut (
    .CLK(clk), .nRST(nrst), .iREN(iren), .dREN(dren), .dWEN(dwen),
    .iaddr(iaddr), .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait),
    .iload(iload), .dload(dload), .ramREN(ren), .ramWEN(wen), .ramaddr(raddr),
    .ramstore(rstore), .ramload(rload), .ramstate(rs), .arb_err(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic vec_t mk(input logic [1:0] i, d, w, s, iw, dw, input logic r, we,
                              input logic [31:0] a, st, input logic [63:0] il, dl);
    vec_t x;
    x = '{i, d, w, s, iw, dw, r, we, a, st, il, dl};
    return x;
  endfunction
  function automatic vec_t idle(input logic [1:0] i, d, w);
    return mk(i, d, w, FREE, 2'b11, 2'b11, 0, 0, 0, 0, 0, 0);
  endfunction
  task automatic step(input logic [1:0] i, d, w, s);
    @(negedge clk);
    iren = i; dren = d; dwen = w; rs = s;
    #1;
  endtask
  initial begin
    // both CPUs streaming data reads: grants 0,1,0,1 with a bubble between each
    for (int k = 0; k < 2; k++) begin
      v.push_back(idle(0, 3, 0));
      v.push_back(mk(0, 3, 0, ACCESS, 3, 2, 1, 0, 32'h200, 32'hDEAD_BEEF, 0, {32'h0, L}));
      v.push_back(idle(0, 3, 0));
      v.push_back(mk(0, 3, 0, ACCESS, 3, 1, 1, 0, 32'h280, 32'hCAFE_F00D, 0, {L, 32'h0}));
    end
    // request dropped mid-transfer: no wait pulse, pointer stays at 0 so CPU0 wins next
    v.push_back(idle(0, 1, 0));
    v.push_back(mk(0, 1, 0, BUSY, 3, 3, 1, 0, 32'h200, 32'hDEAD_BEEF, 0, 0));
    v.push_back(mk(0, 0, 0, BUSY, 3, 3, 0, 0, 32'h200, 32'hDEAD_BEEF, 0, 0));
    v.push_back(idle(0, 0, 0));
    v.push_back(idle(0, 3, 0));
    v.push_back(mk(0, 3, 0, ACCESS, 3, 2, 1, 0, 32'h200, 32'hDEAD_BEEF, 0, {32'h0, L}));
    v.push_back(idle(0, 0, 0));
    // instruction fetch with ACCESS on the second transfer cycle
    v.push_back(idle(1, 0, 0));
    v.push_back(mk(1, 0, 0, BUSY, 3, 3, 1, 0, 32'h100, 0, 0, 0));
    v.push_back(mk(1, 0, 0, ACCESS, 2, 3, 1, 0, 32'h100, 0, {32'h0, L}, 0));
    v.push_back(idle(0, 0, 0));
    // data write (dREN&dWEN) beats instruction, then bubble, then the fetch
    v.push_back(idle(1, 1, 1));
    v.push_back(mk(1, 1, 1, ACCESS, 3, 2, 0, 1, 32'h200, 32'hDEAD_BEEF, 0, 0));
    v.push_back(idle(1, 0, 0));
    v.push_back(mk(1, 0, 0, ACCESS, 2, 3, 1, 0, 32'h100, 0, {32'h0, L}, 0));
    v.push_back(idle(0, 0, 0));
    nrst = 1'b0;
    iren = 0; dren = 0; dwen = 0; rs = FREE; rload = L;
    iaddr = {32'h180, 32'h100};
    daddr = {32'h280, 32'h200};
    dstore = {32'hCAFE_F00D, 32'hDEAD_BEEF};
    repeat (2) @(negedge clk);
    #1;
    chk("reset iwait", 64'(iwait), 64'h3);
    chk("reset dwait", 64'(dwait), 64'h3);
    chk("reset en", {62'h0, ren, wen}, 64'h0);
    chk("reset addr", 64'(raddr), 64'h0);
    chk("reset load", iload | dload, 64'h0);
    chk("reset err", 64'(err), 64'h0);
    @(negedge clk);
    nrst = 1'b1;
    foreach (v[i]) begin
      step(v[i].iren, v[i].dren, v[i].dwen, v[i].rs);
      chk($sformatf("row%0d iwait", i), 64'(iwait), 64'(v[i].iw));
      chk($sformatf("row%0d dwait", i), 64'(dwait), 64'(v[i].dw));
      chk($sformatf("row%0d ramREN", i), 64'(ren), 64'(v[i].ren));
      chk($sformatf("row%0d ramWEN", i), 64'(wen), 64'(v[i].wen));
      chk($sformatf("row%0d ramaddr", i), 64'(raddr), 64'(v[i].addr));
      chk($sformatf("row%0d ramstore", i), 64'(rstore), 64'(v[i].store));
      chk($sformatf("row%0d iload", i), iload, v[i].il);
      chk($sformatf("row%0d dload", i), dload, v[i].dl);
      chk($sformatf("row%0d arb_err", i), 64'(err), 64'h0);
    end
    // asynchronous reset in the middle of a CPU1 transfer
    step(0, 2, 0, BUSY);
    step(0, 2, 0, BUSY);
    chk("mid xfer ren", 64'(ren), 64'h1);
    chk("mid xfer addr", 64'(raddr), 64'h280);
    #1 nrst = 1'b0;
    #1;
    chk("async rst en", {62'h0, ren, wen}, 64'h0);
    chk("async rst waits", {60'h0, iwait, dwait}, 64'hF);
    chk("async rst addr", 64'(raddr), 64'h0);
    step(0, 0, 0, FREE);
    nrst = 1'b1;
    // RAM stuck BUSY on a CPU0 read
    step(0, 1, 0, BUSY);
    for (int k = 1; k <= 8; k++) begin
      step(0, 1, 0, BUSY);
      chk($sformatf("stuck cycle%0d ren", k), 64'(ren), 64'h1);
      chk($sformatf("stuck cycle%0d err", k), 64'(err), 64'h0);
    end
`ifdef MEM_ARB_TIMEOUT_EN
    step(0, 1, 0, BUSY);
    chk("timeout ren", 64'(ren), 64'h0);
    chk("timeout dwait", 64'(dwait), 64'h3);
    chk("timeout err", 64'(err), 64'h1);
    step(0, 1, 0, BUSY);
    chk("regrant ren", 64'(ren), 64'h1);
    step(0, 0, 0, FREE);
    step(0, 0, 0, FREE);
    chk("err sticky", 64'(err), 64'h1);
`else
    repeat (20) step(0, 1, 0, BUSY);
    chk("no timeout ren", 64'(ren), 64'h1);
    chk("no timeout err", 64'(err), 64'h0);
    step(0, 1, 0, ACCESS);
    chk("late access dwait", 64'(dwait), 64'h2);
    chk("late access dload", dload, {32'h0, L});
    step(0, 0, 0, FREE);
    chk("late access idle", 64'(ren), 64'h0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
